shifter_arbiter: RTL and testbench

- Shares one 32-bit left barrel shifter (with fill-bit input) between two requesters, e.g. ALU shift path (port 0) and load/store alignment path (port 1).
- Performs SLL/SRL/SRA. Right shifts are done by bit-reversing the operand, left-shifting, then bit-reversing the result.
- Round-robin arbitration, valid/ready handshakes on both sides, single registered result stage.

---
 rtl/shifter_arbiter.sv | 117 +++++++++++
 tb/tb_shifter_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// Two-port round-robin front end sharing one left barrel shifter; right shifts
// reuse the left shifter by bit-reversing operand and result.
module shifter_arbiter #(
    parameter int unsigned DATA_LENGTH = 32,
    localparam int unsigned SHAMT_W = $clog2(DATA_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [1:0]             req0_op,
    input  logic [DATA_LENGTH-1:0] req0_data,
    input  logic [SHAMT_W-1:0]     req0_shamt,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [1:0]             req1_op,
    input  logic [DATA_LENGTH-1:0] req1_data,
    input  logic [SHAMT_W-1:0]     req1_shamt,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_LENGTH-1:0] res_data,
    output logic                   res_src
);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } shift_op_e;

    logic                   r_res_valid;
    logic [DATA_LENGTH-1:0] r_res_data;
    logic                   r_res_src;
    logic                   r_last_grant;

    logic                   w_grant_valid;
    logic                   w_grant_idx;
    logic                   w_slot_free;
    logic                   w_accept;
    shift_op_e              w_sel_op;
    logic [DATA_LENGTH-1:0] w_sel_data;
    logic [SHAMT_W-1:0]     w_sel_shamt;
    logic                   w_is_right;
    logic                   w_fill;
    logic [DATA_LENGTH-1:0] w_shl_in;
    logic [DATA_LENGTH-1:0] w_fill_mask;
    logic [DATA_LENGTH-1:0] w_shl_out;
    logic [DATA_LENGTH-1:0] w_result;

    function automatic logic [DATA_LENGTH-1:0] bit_rev(input logic [DATA_LENGTH-1:0] x);
        logic [DATA_LENGTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DATA_LENGTH); i++) begin
            r[i] = x[int'(DATA_LENGTH) - 1 - i];
        end
        return r;
    endfunction

    // Round-robin: on a tie the port that did not win last time is granted.
    always_comb begin
        w_grant_valid = req0_valid || req1_valid;
        w_grant_idx   = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_idx = !r_last_grant;
        end else if (req1_valid) begin
            w_grant_idx = 1'b1;
        end
    end

    assign w_slot_free = !r_res_valid || res_ready;
    assign w_accept    = w_grant_valid && w_slot_free && !rst;
    assign req0_ready  = w_accept && !w_grant_idx;
    assign req1_ready  = w_accept && w_grant_idx;

    assign w_sel_op    = shift_op_e'(w_grant_idx ? req1_op : req0_op);
    assign w_sel_data  = w_grant_idx ? req1_data : req0_data;
    assign w_sel_shamt = w_grant_idx ? req1_shamt : req0_shamt;

    // Shared left shifter; vacated low bits take the fill value.
    always_comb begin
        w_is_right  = (w_sel_op == OP_SRL) || (w_sel_op == OP_SRA);
        w_fill      = (w_sel_op == OP_SRA) && w_sel_data[DATA_LENGTH-1];
        w_shl_in    = w_is_right ? bit_rev(w_sel_data) : w_sel_data;
        w_fill_mask = ~({DATA_LENGTH{1'b1}} << w_sel_shamt);
        w_shl_out   = (w_shl_in << w_sel_shamt) | (w_fill ? w_fill_mask : '0);
        if (w_sel_op == OP_PASS) begin
            w_result = w_sel_data;
        end else if (w_is_right) begin
            w_result = bit_rev(w_shl_out);
        end else begin
            w_result = w_shl_out;
        end
    end

    // Result stage: accept overrides drain, so a same-cycle swap keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_src    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_res_valid  <= 1'b1;
            r_res_data   <= w_result;
            r_res_src    <= w_grant_idx;
            r_last_grant <= w_grant_idx;
        end else if (res_ready) begin
            r_res_valid  <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_src   = r_res_src;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed plus randomized bench for shifter_arbiter against a behavioural
// transaction-level model using native shift operators.
module tb_shifter_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_op, req1_op;
    logic [W-1:0]  req0_data, req1_data;
    logic [SW-1:0] req0_shamt, req1_shamt;
    logic          res_valid, res_ready, res_src;
    logic [W-1:0]  res_data;

    int n_cmp = 0;
    int n_err = 0;

    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_src;
    logic         m_last;
    logic         m_acc0, m_acc1;

    always #5 clk = ~clk;

    shifter_arbiter #(.DATA_LENGTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_shamt(req1_shamt),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_src(res_src)
    );

    function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input logic [W-1:0] d,
                                               input logic [SW-1:0] s);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return W'($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check readys against the model, clock, update model, check result regs.
    task automatic cycle();
        logic both, gidx, free, acc;
        #1;
        both = req0_valid && req1_valid;
        gidx = both ? !m_last : (req1_valid && !req0_valid);
        free = !m_valid || res_ready;
        acc  = !rst && free && (req0_valid || req1_valid);
        m_acc0 = acc && !gidx;
        m_acc1 = acc && gidx;
        chk("req0_ready", W'(req0_ready), W'(m_acc0));
        chk("req1_ready", W'(req1_ready), W'(m_acc1));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
        end else if (acc) begin
            m_valid = 1'b1;
            m_src   = gidx;
            m_last  = gidx;
            m_data  = gidx ? ref_shift(req1_op, req1_data, req1_shamt)
                           : ref_shift(req0_op, req0_data, req0_shamt);
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("res_valid", W'(res_valid), W'(m_valid));
        chk("res_data", res_data, m_data);
        chk("res_src", W'(res_src), W'(m_src));
    endtask

    task automatic drv0(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                        input logic [SW-1:0] s);
        req0_valid = v; req0_op = op; req0_data = d; req0_shamt = s;
    endtask

    task automatic drv1(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                        input logic [SW-1:0] s);
        req1_valid = v; req1_op = op; req1_data = d; req1_shamt = s;
    endtask

    initial begin
        m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
        rst = 1'b1; res_ready = 1'b1;
        drv0(1'b0, 2'b00, '0, '0);
        drv1(1'b0, 2'b00, '0, '0);
        @(posedge clk); #1;
        cycle();
        chk("rst_valid", W'(res_valid), '0);
        chk("rst_data", res_data, '0);
        rst = 1'b0;

        // Port 0 SLL 1 by 31
        drv0(1'b1, 2'b00, 32'h0000_0001, 5'd31);
        cycle();
        chk("sll31_ready_seen", W'(m_acc0), 32'd1);
        chk("sll31", res_data, 32'h8000_0000);
        drv0(1'b0, 2'b00, '0, '0);

        // Port 1 SRA then SRL back-to-back
        drv1(1'b1, 2'b10, 32'h8000_0000, 5'd4);
        cycle();
        chk("sra4", res_data, 32'hF800_0000);
        chk("sra4_src", W'(res_src), 32'd1);
        drv1(1'b1, 2'b01, 32'h8000_0000, 5'd4);
        cycle();
        chk("srl4", res_data, 32'h0800_0000);
        chk("srl4_valid", W'(res_valid), 32'd1);
        drv1(1'b0, 2'b00, '0, '0);
        cycle();
        chk("drained", W'(res_valid), '0);

        // Fairness after reset
        rst = 1'b1; cycle(); rst = 1'b0;
        drv0(1'b1, 2'b00, 32'h1, 5'd1);
        drv1(1'b1, 2'b11, 32'hDEAD_BEEF, 5'd7);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_src", W'(res_src), W'(i % 2));
            chk("rr_data", res_data, (i % 2 == 0) ? 32'h0000_0002 : 32'hDEAD_BEEF);
        end
        drv1(1'b0, 2'b00, '0, '0);

        // Backpressure then same-cycle drain and accept
        drv0(1'b1, 2'b11, 32'h1234_5678, 5'd3);
        cycle();
        res_ready = 1'b0;
        drv0(1'b1, 2'b00, 32'h1, 5'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold", res_data, 32'h1234_5678);
            chk("bp_ready0", W'(req0_ready), '0);
        end
        res_ready = 1'b1;
        cycle();
        chk("swap_valid", W'(res_valid), 32'd1);
        chk("swap_data", res_data, 32'h0000_0002);
        drv0(1'b0, 2'b00, '0, '0);

        // Reset mid-operation, then first tie goes to port 0
        rst = 1'b1;
        cycle();
        chk("midrst_valid", W'(res_valid), '0);
        rst = 1'b0;
        drv0(1'b1, 2'b00, 32'h3, 5'd2);
        drv1(1'b1, 2'b11, 32'h5, 5'd0);
        cycle();
        chk("post_rst_src", W'(res_src), '0);
        chk("post_rst_data", res_data, 32'hC);
        drv1(1'b0, 2'b00, '0, '0);

        // Boundaries
        drv0(1'b1, 2'b10, 32'h7FFF_FFFF, 5'd31);
        cycle();
        chk("sra_max_pos", res_data, 32'h0000_0000);
        drv0(1'b1, 2'b10, 32'hFFFF_FFFF, 5'd0);
        cycle();
        chk("sra_zero", res_data, 32'hFFFF_FFFF);
        drv0(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd31);
        cycle();
        chk("srl_max", res_data, 32'h0000_0001);
        drv0(1'b0, 2'b00, '0, '0);

        // Random traffic; pending requests keep their fields stable
        for (int i = 0; i < 3000; i++) begin
            if (!(req0_valid && !m_acc0) || ($urandom_range(0, 15) == 0))
                drv0(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
                     ($urandom_range(0, 3) == 0) ? SW'(($urandom_range(0, 1) != 0) ? 31 : 0)
                                                 : SW'($urandom));
            if (!(req1_valid && !m_acc1) || ($urandom_range(0, 15) == 0))
                drv1(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
                     ($urandom_range(0, 3) == 0) ? SW'(($urandom_range(0, 1) != 0) ? 31 : 0)
                                                 : SW'($urandom));
            res_ready = 1'($urandom_range(0, 3) != 0);
            rst = 1'($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
